// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: one transaction in flight at a time, with a
// per-access timeout that aborts a stalled memory access and reports it through err.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          p0_req,
    input  logic          p1_req,
    input  logic          p0_we,
    input  logic          p1_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [DW-1:0] p1_wdata,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e          state_q;
    logic            last_owner_q;
    logic            owner_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;
    logic            busy_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic            win;
    logic            timed_out;

    // On a tie the port that did not own the previous transaction wins.
    assign win       = (p0_req && p1_req) ? ~last_owner_q : p1_req;
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        owner_q      <= win;
                        last_owner_q <= win;
                        gnt_q        <= win ? 2'b10 : 2'b01;
                        mem_we_q     <= win ? p1_we : p0_we;
                        mem_addr_q   <= win ? p1_addr : p0_addr;
                        mem_wdata_q  <= win ? p1_wdata : p0_wdata;
                        mem_req_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (mem_ready || timed_out) begin
                        done_q    <= owner_q ? 2'b10 : 2'b01;
                        err_q     <= ~mem_ready;
                        rdata_q   <= (mem_ready && !mem_we_q) ? mem_rdata : '0;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for reset, held-request round-robin and reset during an access.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [1:0]  gnt, done;
    logic        err, busy, mem_req, mem_we, mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .p0_req   (p0_req),
        .p1_req   (p1_req),
        .p0_we    (p0_we),
        .p1_we    (p1_we),
        .p0_addr  (p0_addr),
        .p1_addr  (p1_addr),
        .p0_wdata (p0_wdata),
        .p1_wdata (p1_wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          delay;   // ACCESS cycle in which mem_ready is high, 0 = never
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_done;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        logic stable;
        int   k;
        if (v.exp_gnt[1]) begin
            p1_we = v.we;  p1_addr = v.addr;  p1_wdata = v.wdata;
            p0_we = ~v.we; p0_addr = ~v.addr; p0_wdata = ~v.wdata;
        end else begin
            p0_we = v.we;  p0_addr = v.addr;  p0_wdata = v.wdata;
            p1_we = ~v.we; p1_addr = ~v.addr; p1_wdata = ~v.wdata;
        end
        p0_req = v.req[0];
        p1_req = v.req[1];
        mem_ready = 1'b0;
        tick();
        check($sformatf("v%0d gnt", idx), gnt, v.exp_gnt);
        check($sformatf("v%0d mem_req/busy", idx), {mem_req, busy}, 2'b11);
        check($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
        check($sformatf("v%0d mem_we/wdata", idx), {mem_we, mem_wdata}, {v.we, v.wdata});
        p0_req = 1'b0; p1_req = 1'b0;
        p0_addr = 32'hFFFF_0000; p1_addr = 32'h0000_FFFF;
        stable = 1'b1;
        k = 0;
        do begin
            k++;
            mem_ready = (k == v.delay);
            mem_rdata = v.mrd;
            tick();
            if (done == 2'b00)
                stable &= mem_req && busy && (gnt == 2'b00) && (mem_we == v.we) &&
                          (mem_addr == v.addr) && (mem_wdata == v.wdata);
        end while (done == 2'b00 && k < 24);
        check($sformatf("v%0d access cycles", idx), k, v.exp_cycles);
        check($sformatf("v%0d stable in access", idx), stable, 1'b1);
        check($sformatf("v%0d done", idx), done, v.exp_done);
        check($sformatf("v%0d err", idx), err, v.exp_err);
        check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        check($sformatf("v%0d mem_req/busy end", idx), {mem_req, busy}, 2'b00);
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        tick();
        check($sformatf("v%0d idle after", idx), {gnt, done}, 4'b0000);
        check($sformatf("v%0d rdata hold", idx), rdata, v.exp_rdata);
    endtask

    initial begin
        // req, we, addr, wdata, mem_rdata, delay, gnt, done, err, rdata, cycles
        vecs[0] = '{2'b01, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                    2'b01, 2'b01, 1'b0, 32'hDEADBEEF, 1};
        vecs[1] = '{2'b10, 1'b1, 32'h40, 32'h12345678, 32'hAAAA5555, 5,
                    2'b10, 2'b10, 1'b0, 32'h0, 5};
        vecs[2] = '{2'b01, 1'b0, 32'h200, 32'h0, 32'h11112222, 0,
                    2'b01, 2'b01, 1'b1, 32'h0, 16};
        vecs[3] = '{2'b11, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 2,
                    2'b10, 2'b10, 1'b0, 32'h0BADF00D, 2};
        vecs[4] = '{2'b11, 1'b1, 32'h304, 32'hCAFE0001, 32'h77778888, 3,
                    2'b01, 2'b01, 1'b0, 32'h0, 3};
        vecs[5] = '{2'b10, 1'b0, 32'h500, 32'h0, 32'hCAFEF00D, 16,
                    2'b10, 2'b10, 1'b0, 32'hCAFEF00D, 16};
        vecs[6] = '{2'b01, 1'b1, 32'h600, 32'h87654321, 32'h99990000, 1,
                    2'b01, 2'b01, 1'b0, 32'h0, 1};

        // Reset with activity on the inputs.
        rstn = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1; p1_we = 1'b1;
        p0_addr = 32'h1234; p1_addr = 32'h5678; p0_wdata = 32'h1; p1_wdata = 32'h2;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        check("reset gnt/done/err/busy/mem_req", {gnt, done, err, busy, mem_req, mem_we}, '0);
        check("reset rdata", rdata, 32'h0);
        check("reset mem_addr/wdata", {mem_addr, mem_wdata}, 64'h0);

        // mem_ready in IDLE is ignored.
        p0_req = 1'b0; p1_req = 1'b0;
        rstn = 1'b1;
        tick();
        tick();
        check("idle ready ignored", {gnt, done, busy, mem_req}, '0);

        // Both requests held: grant order 0, 1, 0 with one IDLE edge between.
        p0_we = 1'b0; p1_we = 1'b0; p0_addr = 32'hA0; p1_addr = 32'hB0;
        p0_req = 1'b1; p1_req = 1'b1;
        tick();
        check("rr grant 1", gnt, 2'b01);
        check("rr addr 1", mem_addr, 32'hA0);
        tick();
        check("rr done 1", {gnt, done}, 4'b0001);
        tick();
        check("rr grant 2", gnt, 2'b10);
        check("rr addr 2", mem_addr, 32'hB0);
        tick();
        check("rr done 2", {gnt, done}, 4'b0010);
        tick();
        check("rr grant 3", gnt, 2'b01);
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        check("rr done 3", {gnt, done}, 4'b0001);
        mem_ready = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Reset asserted during the third ACCESS cycle abandons the transaction.
        p0_we = 1'b0; p0_addr = 32'h700; p0_req = 1'b1;
        tick();
        check("rst-access grant", gnt, 2'b01);
        p0_req = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        check("rst-access no done", {done, mem_req, busy}, '0);
        rstn = 1'b1;
        p1_we = 1'b0; p1_addr = 32'h800; p1_req = 1'b1;
        tick();
        check("post-reset p1 grant", gnt, 2'b10);
        check("post-reset addr", mem_addr, 32'h800);
        p1_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0F0F_1234;
        tick();
        check("post-reset done", {done, err}, 3'b100);
        check("post-reset rdata", rdata, 32'h0F0F_1234);
        mem_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 32, address width; DW, default 32, data width; TIMEOUT, default 16, maximum ACCESS cycles before abort (>=2).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- p0_req, p1_req  in  1  port 0 (CPU) / port 1 (loader) request, level
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  AW  byte address
- p0_wdata, p1_wdata  in  DW  write data
- gnt  out  2  one-hot grant pulse, bit i = port i
- done  out  2  one-hot completion pulse, bit i = port i
- err  out  1  timeout flag, valid only while done != 0
- rdata  out  DW  read data, valid while done != 0
- busy  out  1  transaction in flight
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ready  in  1  memory completes access this cycle
- mem_rdata  in  DW  memory read data, valid with mem_ready

Function
REQ-003 SHALL implement FSM with states IDLE and ACCESS; all outputs registered.
REQ-004 IDLE, no req sampled: SHALL stay IDLE, mem_req=0, gnt=0.
REQ-005 IDLE, exactly one req sampled: SHALL grant that port at that edge.
REQ-006 IDLE, both reqs sampled: SHALL grant the port != last_owner (round-robin); last_owner resets to 1, so port 0 wins the first tie.
REQ-007 On grant: SHALL latch winner's we/addr/wdata onto mem_we/mem_addr/mem_wdata, set mem_req=1, busy=1, pulse gnt[winner] for exactly one cycle, update last_owner, clear timeout counter, enter ACCESS.
REQ-008 In ACCESS: mem_req/mem_we/mem_addr/mem_wdata SHALL remain stable; requests on either port SHALL be ignored (no gnt).
REQ-009 ACCESS with mem_ready sampled high: SHALL pulse done[owner] one cycle, err=0, rdata=mem_rdata for reads (0 for writes), set mem_req=0, busy=0, return to IDLE.
REQ-010 ACCESS without mem_ready: SHALL increment timeout counter; at TIMEOUT ACCESS cycles without mem_ready, SHALL pulse done[owner] with err=1, rdata=0, mem_req=0, busy=0, return to IDLE.
REQ-011 mem_ready high and counter reaching TIMEOUT in the same cycle: completion SHALL win (err=0).
REQ-012 mem_ready in IDLE SHALL be ignored.
REQ-013 Minimum latency: grant edge to done edge = 1 cycle; next grant no earlier than the edge after done (one IDLE cycle between transactions).
REQ-014 Requester SHALL drop req in the cycle after gnt unless issuing another transaction; req held high SHALL produce a new transaction at the next IDLE edge.
REQ-015 rdata SHALL hold its value when done=0; done and gnt SHALL never have more than one bit set.

Reset
REQ-016 rstn=0 at an edge SHALL force IDLE, gnt=0, done=0, err=0, rdata=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, last_owner=1.
REQ-017 Reset during ACCESS SHALL abandon the transaction with no done pulse; first edge after rstn=1 behaves as IDLE.

Verification
REQ-018 P0 read addr 0x100, mem_ready 1 cycle after mem_req with mem_rdata 0xDEADBEEF -> gnt=01 one cycle, then done=01, rdata=0xDEADBEEF, err=0.
REQ-019 p0_req and p1_req high together from reset, held for 3 transactions, mem_ready immediate -> grant order port0, port1, port0.
REQ-020 P1 write addr 0x40 data 0x12345678, mem_ready after 5 cycles -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 stable 5 cycles, then done=10, err=0.
REQ-021 P0 read, mem_ready never asserted, TIMEOUT=16 -> done=01, err=1, rdata=0 after 16 ACCESS cycles; mem_req drops.
REQ-022 rstn low on 3rd ACCESS cycle -> no done pulse, mem_req=0 next cycle; p1_req after release granted normally.
REQ-023 mem_ready coincident with the TIMEOUT-th ACCESS cycle -> done with err=0 and rdata=mem_rdata.
